// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and defaults for the memory fill arbiter.
// Holds the FSM state encoding, the owner encoding and the block geometry defaults.
package mem_fill_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int BLOCK_WORDS_DEF = 8;
  localparam int IDX_W_DEF       = 3;
  localparam int DATA_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the single-ported pipelined memory between the I-side and D-side miss handlers.
// Reads issue a whole block back to back; returned words are steered to the owner by arrival count.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_W-1:0]     i_fill_data,
  output logic [IDX_W-1:0]      i_fill_idx,
  output logic                  i_fill_valid,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_fill_data,
  output logic [IDX_W-1:0]      d_fill_idx,
  output logic                  d_fill_valid,
  output logic                  d_done,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_valid,
  output state_e                dbg_state
);

  localparam logic [IDX_W:0]   ISSUE_END = (IDX_W+1)'(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] RX_LAST   = IDX_W'(BLOCK_WORDS - 1);

  state_e                  state_q;
  owner_e                  owner_q;
  owner_e                  last_grant_q;
  logic [IDX_W:0]          issue_cnt_q;
  logic [IDX_W-1:0]        rx_cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    mem_en_q;
  logic                    mem_wr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_W-1:0]       mem_wdata_q;

  owner_e                  grant_d;
  logic [ADDR_WIDTH-1:0]   grant_base_d;
  logic [ADDR_WIDTH-1:0]   issue_addr_d;
  logic                    rd_fill;
  logic                    rx_last;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[IDX_W:0], d_addr[0]};

  // Round-robin only matters on a tie: D wins when I had the last grant.
  assign grant_d = (d_req && (!i_req || last_grant_q == OWN_I)) ? OWN_D : OWN_I;

  always_comb begin
    grant_base_d = (grant_d == OWN_D) ? d_addr : i_addr;
    grant_base_d[IDX_W:0] = '0;
  end

  assign issue_addr_d = base_q + {{(ADDR_WIDTH-IDX_W-1){1'b0}}, issue_cnt_q[IDX_W-1:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      last_grant_q <= OWN_I;
      issue_cnt_q  <= '0;
      rx_cnt_q     <= '0;
      base_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            mem_en_q     <= 1'b1;
            if (grant_d == OWN_D && d_wr) begin
              state_q     <= ST_WRITE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {d_addr[ADDR_WIDTH-1:1], 1'b0};
              mem_wdata_q <= d_wdata;
            end else begin
              // First word goes out the cycle after the grant, so the count starts at one.
              state_q     <= ST_READ;
              base_q      <= grant_base_d;
              mem_addr_q  <= grant_base_d;
              issue_cnt_q <= (IDX_W+1)'(1);
              rx_cnt_q    <= '0;
            end
          end
        end
        ST_WRITE: begin
          state_q     <= ST_IDLE;
          owner_q     <= OWN_NONE;
          mem_en_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        ST_READ: begin
          if (issue_cnt_q < ISSUE_END) begin
            mem_en_q    <= 1'b1;
            mem_addr_q  <= issue_addr_d;
            issue_cnt_q <= issue_cnt_q + (IDX_W+1)'(1);
          end else begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
          end
          if (mem_valid) begin
            if (rx_last) begin
              state_q     <= ST_IDLE;
              owner_q     <= OWN_NONE;
              issue_cnt_q <= '0;
              rx_cnt_q    <= '0;
              mem_en_q    <= 1'b0;
              mem_addr_q  <= '0;
            end else begin
              rx_cnt_q <= rx_cnt_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          owner_q  <= OWN_NONE;
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  // Fill path is combinational so a word reaches the owner in the cycle it returns.
  assign rd_fill = !rst && (state_q == ST_READ) && mem_valid;
  assign rx_last = (rx_cnt_q == RX_LAST);

  assign i_fill_valid = rd_fill && (owner_q == OWN_I);
  assign d_fill_valid = rd_fill && (owner_q == OWN_D);
  assign i_fill_data  = i_fill_valid ? mem_rdata : '0;
  assign d_fill_data  = d_fill_valid ? mem_rdata : '0;
  assign i_fill_idx   = i_fill_valid ? rx_cnt_q : '0;
  assign d_fill_idx   = d_fill_valid ? rx_cnt_q : '0;
  assign i_done       = i_fill_valid && rx_last;
  assign d_done       = (d_fill_valid && rx_last) || (!rst && state_q == ST_WRITE);

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-deep pipelined memory model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_mem_fill_arbiter;
  import mem_fill_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_fill_data;
  logic [2:0]  i_fill_idx;
  logic        i_fill_valid;
  logic        i_done;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_fill_data;
  logic [2:0]  d_fill_idx;
  logic        d_fill_valid;
  logic        d_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_mem [0:32767];

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_fill_data(i_fill_data), .i_fill_idx(i_fill_idx),
    .i_fill_valid(i_fill_valid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_data(d_fill_data), .d_fill_idx(d_fill_idx), .d_fill_valid(d_fill_valid), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .dbg_state(dbg_state)
  );

  // Memory model: 1-cycle write, read data valid 4 cycles after the enable; pipeline shares rst.
  logic [15:0] mem [0:32767];
  logic [3:0]  pv;
  logic [15:0] pd [4];
  bit          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int n = 0; n < 32768; n++) mem[n] <= 16'(n);
      mem_init_done <= 1'b1;
    end else if (mem_en && mem_wr && !rst) begin
      mem[mem_addr[15:1]] <= mem_wdata;
    end
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], mem_en && !mem_wr};
      pd[0] <= mem[mem_addr[15:1]];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end

  assign mem_valid = pv[3];
  assign mem_rdata = pd[3];

  typedef struct {
    bit          side;      // 0 = I, 1 = D
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_addr;  // block base for reads, aligned word address for writes
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ctl"}, {24'd0, mem_en, mem_wr, i_fill_valid, i_done, d_fill_valid, d_done, 2'b00}, 32'd0);
    chk({tag, " idx"}, {26'd0, i_fill_idx, d_fill_idx}, 32'd0);
    chk({tag, " addr/wdata"}, {mem_addr, mem_wdata}, 32'd0);
    chk({tag, " fill data"}, {i_fill_data, d_fill_data}, 32'd0);
  endtask

  // Called at the sample point of the grant cycle (request already visible).
  task automatic expect_read(input bit side, input logic [15:0] base,
                             input int drop_at, input int raise_d_at, input int abort_at);
    logic [15:0] a;
    logic [15:0] w;
    logic        ofv, odone, xfv, xdone;
    logic [2:0]  oidx;
    logic [15:0] odata;
    string       s;
    s = side ? "D" : "I";
    chk($sformatf("%s rd c0 state", s), 32'(dbg_state), 32'(ST_IDLE));
    chk_quiet($sformatf("%s rd c0", s));
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_q.push_back(exp_mem[a[15:1]]);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      ofv   = side ? d_fill_valid : i_fill_valid;
      odone = side ? d_done : i_done;
      oidx  = side ? d_fill_idx : i_fill_idx;
      odata = side ? d_fill_data : i_fill_data;
      xfv   = side ? i_fill_valid : d_fill_valid;
      xdone = side ? i_done : d_done;
      chk($sformatf("%s rd c%0d mem_en", s, c), 32'(mem_en), 32'(c <= 8));
      chk($sformatf("%s rd c%0d mem_wr", s, c), 32'(mem_wr), 32'd0);
      if (c <= 8) chk($sformatf("%s rd c%0d mem_addr", s, c), 32'(mem_addr), 32'(16'(base + 16'(2 * (c - 1)))));
      chk($sformatf("%s rd c%0d fill_valid", s, c), 32'(ofv), 32'(c >= 5));
      if (c >= 5) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk($sformatf("%s rd c%0d fill_idx", s, c), 32'(oidx), 32'(c - 5));
        chk($sformatf("%s rd c%0d fill_data", s, c), 32'(odata), 32'(w));
      end
      chk($sformatf("%s rd c%0d done", s, c), 32'(odone), 32'(c == 12));
      chk($sformatf("%s rd c%0d other side", s, c), {30'd0, xfv, xdone}, 32'd0);
      if (c == drop_at) begin
        if (side) d_req = 1'b0; else i_req = 1'b0;
      end
      if (c == raise_d_at) begin
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
      end
      if (c == abort_at) begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        tick();
        chk($sformatf("%s abort state", s), 32'(dbg_state), 32'(ST_IDLE));
        chk_quiet($sformatf("%s abort", s));
        exp_q.delete();
        return;
      end
    end
    chk($sformatf("%s rd scoreboard left", s), 32'(exp_q.size()), 32'd0);
  endtask

  // Called at the sample point of the grant cycle for a D write.
  task automatic expect_write(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] wa;
    wa = {addr[15:1], 1'b0};
    chk("wr c0 state", 32'(dbg_state), 32'(ST_IDLE));
    chk_quiet("wr c0");
    tick();
    chk("wr c1 en/wr/d_done", {29'd0, mem_en, mem_wr, d_done}, 32'h7);
    chk("wr c1 addr", 32'(mem_addr), 32'(wa));
    chk("wr c1 wdata", 32'(mem_wdata), 32'(data));
    chk("wr c1 fills/i_done", {29'd0, i_fill_valid, d_fill_valid, i_done}, 32'd0);
    exp_mem[wa[15:1]] = data;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    chk_quiet("reset");
    rst = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 32768; n++) exp_mem[n] = 16'(n);
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    vecs[0] = '{side: 1'b0, wr: 1'b0, addr: 16'h1236, wdata: 16'h0000, exp_addr: 16'h1230};
    vecs[1] = '{side: 1'b1, wr: 1'b1, addr: 16'h0042, wdata: 16'hBEEF, exp_addr: 16'h0042};
    vecs[2] = '{side: 1'b1, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, exp_addr: 16'h0040};
    vecs[3] = '{side: 1'b1, wr: 1'b1, addr: 16'h0047, wdata: 16'h1234, exp_addr: 16'h0046};
    vecs[4] = '{side: 1'b0, wr: 1'b0, addr: 16'h004F, wdata: 16'h0000, exp_addr: 16'h0040};
    vecs[5] = '{side: 1'b1, wr: 1'b0, addr: 16'h7FFE, wdata: 16'h0000, exp_addr: 16'h7FF0};
    vecs[6] = '{side: 1'b0, wr: 1'b0, addr: 16'h0A5A, wdata: 16'h0000, exp_addr: 16'h0A50};

    tick();
    do_reset();

    // Single-requester transactions from the table.
    foreach (vecs[v]) begin
      if (vecs[v].side) begin
        d_req = 1'b1; d_wr = vecs[v].wr; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      if (vecs[v].wr) expect_write(vecs[v].addr, vecs[v].wdata);
      else            expect_read(vecs[v].side, vecs[v].exp_addr, -1, -1, -1);
      i_req = 1'b0; d_req = 1'b0;
      tick();
      chk($sformatf("vec%0d idle after", v), {31'd0, mem_en}, 32'd0);
      tick();
      chk($sformatf("vec%0d stays idle", v), 32'(dbg_state), 32'(ST_IDLE));
    end

    // Simultaneous requests after reset, then both held: D, I, D, I, D, I.
    do_reset();
    i_req = 1'b1; i_addr = 16'h0300;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0408;
    for (int k = 0; k < 6; k++) begin
      expect_read((k % 2) == 0, (k % 2) == 0 ? 16'h0400 : 16'h0300, -1, -1, -1);
      if (k == 5) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end
    chk_quiet("after alternation");

    // Reset during an I read, then a clean D read.
    i_req = 1'b1; i_addr = 16'h1236;
    expect_read(1'b0, 16'h1230, -1, -1, 6);
    rst = 1'b0;
    tick();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    expect_read(1'b1, 16'h0200, -1, -1, -1);
    d_req = 1'b0;
    tick();

    // Top-of-memory block; I drops req mid-fill, D arrives mid-fill and must wait.
    i_req = 1'b1; i_addr = 16'hFFF0;
    expect_read(1'b0, 16'hFFF0, 3, 6, -1);
    tick();
    expect_read(1'b1, 16'h0100, -1, -1, -1);
    d_req = 1'b0;
    tick();
    chk_quiet("final idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
